player_movement: RTL and testbench
==================================

PLAYER_MOVEMENT -- requirements
Module: player_movement

Interface
REQ-001 SHALL have parameter TILE_SIZE, default 32: step size in pixels.
REQ-002 SHALL have parameters H_VISIBLE_AREA, default 640, and V_VISIBLE_AREA, default 480: playfield size in pixels.
REQ-003 SHALL have parameters c_X_BASE_POSITION, default 320, and c_Y_BASE_POSITION, default 384: spawn corner.
REQ-004 SHALL have parameter FIRST_DELAY, default 3125000: cycles from the first step to the first auto-repeat step.
REQ-005 SHALL have parameter REPEAT_DELAY, default 1562500: cycles between later auto-repeat steps.
REQ-006 SHALL have parameter RESPAWN_CYCLES, default 25000000: length of the post-hit respawn window.
REQ-007 SHALL have parameter BLINK_BIT, default 22: counter bit that drives blinking during respawn.
REQ-008 SHALL have parameter c_LIVES_INI, default 3, range 1-7: starting lives.
REQ-009 SHALL have parameter SCORE_WIDTH, default 6: score width.
REQ-010 SHALL have ports, clock and reset first:
- i_Clk in 1: the single clock.
- i_Rst in 1: reset, synchronous, active-high.
- i_Game_Active in 1: run enable.
- i_Dir in 4: {Up,Dn,Lt,Rt} requests.
- i_Has_Collided in 1: hit by a hazard.
- o_Frog_X out 10: top-left X.
- o_Frog_Y out 10: top-left Y.
- o_Draw_Frog out 1: sprite visible.
- o_Score out SCORE_WIDTH: goals reached.
- o_Lives out 3: remaining lives.
- o_Level_Up out 1: 1-cycle pulse on a goal.
- o_Moved out 1: 1-cycle pulse on a position step.
- o_Game_Over out 1: lives exhausted.

Function
REQ-011 SHALL treat a request as valid only when exactly one bit of i_Dir is 1. Zero bits or two or more bits SHALL mean no request.
REQ-012 SHALL implement FSM states IDLE, FIRST_WAIT, REPEAT_WAIT, RELEASE, RESPAWN and OVER, with one counter shared by all states.
REQ-013 IDLE: a valid request sampled at edge k SHALL update the position at edge k, clear the counter, latch the direction and enter FIRST_WAIT.
REQ-014 FIRST_WAIT: with the latched direction held, the next step SHALL occur at edge k+FIRST_DELAY and the FSM SHALL then enter REPEAT_WAIT.
REQ-015 REPEAT_WAIT: a step SHALL occur every REPEAT_DELAY cycles while the latched direction is held.
REQ-016 In FIRST_WAIT or REPEAT_WAIT, a change of i_Dir to any value other than the latched direction SHALL return the FSM to IDLE with no step on that edge.
REQ-017 Step rules:
- Up: if Y > TILE_SIZE, Y -= TILE_SIZE; otherwise this is a goal.
- Dn: if Y < V_VISIBLE_AREA-TILE_SIZE, Y += TILE_SIZE.
- Lt: if X >= TILE_SIZE, X -= TILE_SIZE.
- Rt: if X+TILE_SIZE <= H_VISIBLE_AREA-TILE_SIZE, X += TILE_SIZE.
REQ-018 A blocked step SHALL leave the position unchanged, SHALL NOT pulse o_Moved, and SHALL leave repeat timing unaffected. Every non-blocked step SHALL pulse o_Moved.
REQ-019 Goal:
- X and Y SHALL return to base.
- o_Score SHALL increment, saturating at 2^SCORE_WIDTH-1.
- o_Level_Up SHALL pulse for 1 cycle.
- The FSM SHALL enter RELEASE.
REQ-020 RELEASE: the FSM SHALL stay in RELEASE until i_Dir==0, then go to IDLE. No step SHALL occur in RELEASE.
REQ-021 Collision, in IDLE, FIRST_WAIT, REPEAT_WAIT or RELEASE:
- Collision SHALL take priority over any step or goal on the same edge.
- X and Y SHALL return to base.
- o_Lives SHALL decrement.
- o_Score SHALL be unchanged.
REQ-022 After a collision, if o_Lives becomes 0 the FSM SHALL enter OVER; otherwise it SHALL clear the counter and enter RESPAWN.
REQ-023 RESPAWN: i_Dir and i_Has_Collided SHALL be ignored and o_Draw_Frog SHALL equal ~counter[BLINK_BIT]. After RESPAWN_CYCLES cycles the FSM SHALL enter RELEASE.
REQ-024 OVER: o_Game_Over=1, o_Draw_Frog=0, and all inputs except i_Rst SHALL be ignored until reset.
REQ-025 Outside RESPAWN and OVER, o_Draw_Frog SHALL be 1.
REQ-026 While i_Game_Active=0, state, counter, position, score and lives SHALL freeze and o_Moved and o_Level_Up SHALL be 0. Resuming SHALL continue from the frozen counter value.
REQ-027 The counter SHALL be at least 32 bits wide and SHALL NOT wrap within any single wait.

Reset
REQ-028 When i_Rst=1 at an edge, regardless of i_Game_Active, the block SHALL reset to:
- o_Frog_X=c_X_BASE_POSITION, o_Frog_Y=c_Y_BASE_POSITION.
- o_Score=0, o_Lives=c_LIVES_INI.
- o_Draw_Frog=1, o_Level_Up=0, o_Moved=0, o_Game_Over=0.
- counter=0, state=RELEASE.
REQ-029 Reset mid-operation, including in OVER, SHALL take effect on that edge. A direction held through reset SHALL cause no step until released.

Verification (bench parameters: FIRST_DELAY=4, REPEAT_DELAY=2, RESPAWN_CYCLES=8, BLINK_BIT=1, c_LIVES_INI=2)
REQ-030 Release reset with i_Dir=0, then pulse Up for 1 cycle -> Y 384->352 and o_Moved pulses once; no further step.
REQ-031 Hold Rt from X=320 -> X=352 at edge k, 384 at k+4, 416 at k+6, 448 at k+8, ..., stopping at 608 with no o_Moved after that.
REQ-032 i_Dir=Up|Lt held -> no position change and no pulses. Then change to Dn alone during REPEAT_WAIT -> IDLE, then Dn steps on the following sampled edge.
REQ-033 From Y=32, press Up -> position returns to (320,384), o_Score 0->1 and o_Level_Up pulses once; Up held causes no step until i_Dir==0.
REQ-034 Collision while Up is stepping -> (320,384), o_Lives 2->1, o_Draw_Frog toggles for 8 cycles with i_Dir ignored. A second collision after release -> o_Lives=0, o_Game_Over=1, o_Draw_Frog=0; then i_Rst -> all reset values.
REQ-035 i_Game_Active=0 mid-FIRST_WAIT for 10 cycles -> nothing changes. After reactivation the remaining delay elapses before the repeat step.

Source files
------------

// File: rtl/player_movement.sv
// Grid-stepping player: one-hot direction requests with hold-to-repeat,
// goal scoring, collision/lives handling, blinking respawn and game over.
module player_movement #(
  parameter int TILE_SIZE         = 32,
  parameter int H_VISIBLE_AREA    = 640,
  parameter int V_VISIBLE_AREA    = 480,
  parameter int c_X_BASE_POSITION = 320,
  parameter int c_Y_BASE_POSITION = 384,
  parameter int FIRST_DELAY       = 3125000,
  parameter int REPEAT_DELAY      = 1562500,
  parameter int RESPAWN_CYCLES    = 25000000,
  parameter int BLINK_BIT         = 22,
  parameter int c_LIVES_INI       = 3,
  parameter int SCORE_WIDTH       = 6
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Game_Active,
  input  logic [3:0]             i_Dir,
  input  logic                   i_Has_Collided,
  output logic [9:0]             o_Frog_X,
  output logic [9:0]             o_Frog_Y,
  output logic                   o_Draw_Frog,
  output logic [SCORE_WIDTH-1:0] o_Score,
  output logic [2:0]             o_Lives,
  output logic                   o_Level_Up,
  output logic                   o_Moved,
  output logic                   o_Game_Over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST_WAIT,
    S_REPEAT_WAIT,
    S_RELEASE,
    S_RESPAWN,
    S_OVER
  } state_t;

  localparam logic [9:0]             TILE         = 10'(TILE_SIZE);
  localparam logic [10:0]            X_LIMIT      = 11'(H_VISIBLE_AREA - TILE_SIZE);
  localparam logic [9:0]             Y_LIMIT      = 10'(V_VISIBLE_AREA - TILE_SIZE);
  localparam logic [9:0]             X_BASE       = 10'(c_X_BASE_POSITION);
  localparam logic [9:0]             Y_BASE       = 10'(c_Y_BASE_POSITION);
  localparam logic [31:0]            FIRST_LAST   = 32'(FIRST_DELAY - 1);
  localparam logic [31:0]            REPEAT_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0]            RESPAWN_LAST = 32'(RESPAWN_CYCLES - 1);
  localparam logic [2:0]             LIVES_INI    = 3'(c_LIVES_INI);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX    = '1;

  state_t                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [3:0]             dir_q, dir_d;
  logic [9:0]             x_q, x_d;
  logic [9:0]             y_q, y_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic [2:0]             lives_q, lives_d;
  logic                   moved_q, moved_d;
  logic                   level_up_q, level_up_d;

  logic                   dir_valid;
  logic                   do_step;
  logic                   step_ok;
  logic                   step_goal;
  logic [9:0]             step_x;
  logic [9:0]             step_y;
  logic                   can_collide;

  // A request counts only when exactly one direction bit is set.
  assign dir_valid = (i_Dir != 4'd0) && ((i_Dir & (i_Dir - 4'd1)) == 4'd0);

  assign can_collide = (state_q == S_IDLE) || (state_q == S_FIRST_WAIT) ||
                       (state_q == S_REPEAT_WAIT) || (state_q == S_RELEASE);

  // Candidate move for the current request; step_ok=0 with step_goal=0 is a blocked step.
  always_comb begin
    step_x    = x_q;
    step_y    = y_q;
    step_ok   = 1'b0;
    step_goal = 1'b0;
    if (i_Dir[3]) begin
      if (y_q > TILE) begin
        step_y  = y_q - TILE;
        step_ok = 1'b1;
      end else begin
        step_goal = 1'b1;
      end
    end else if (i_Dir[2]) begin
      if (y_q < Y_LIMIT) begin
        step_y  = y_q + TILE;
        step_ok = 1'b1;
      end
    end else if (i_Dir[1]) begin
      if (x_q >= TILE) begin
        step_x  = x_q - TILE;
        step_ok = 1'b1;
      end
    end else if (i_Dir[0]) begin
      if (({1'b0, x_q} + {1'b0, TILE}) <= X_LIMIT) begin
        step_x  = x_q + TILE;
        step_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    x_d        = x_q;
    y_d        = y_q;
    score_d    = score_q;
    lives_d    = lives_q;
    moved_d    = 1'b0;
    level_up_d = 1'b0;
    do_step    = 1'b0;

    if (i_Game_Active) begin
      if (can_collide && i_Has_Collided) begin
        x_d     = X_BASE;
        y_d     = Y_BASE;
        lives_d = lives_q - 3'd1;
        cnt_d   = '0;
        state_d = (lives_q == 3'd1) ? S_OVER : S_RESPAWN;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (dir_valid) begin
              do_step = 1'b1;
              cnt_d   = '0;
              dir_d   = i_Dir;
              state_d = S_FIRST_WAIT;
            end
          end
          S_FIRST_WAIT: begin
            if (i_Dir != dir_q) begin
              state_d = S_IDLE;
            end else if (cnt_q == FIRST_LAST) begin
              do_step = 1'b1;
              cnt_d   = '0;
              state_d = S_REPEAT_WAIT;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          S_REPEAT_WAIT: begin
            if (i_Dir != dir_q) begin
              state_d = S_IDLE;
            end else if (cnt_q == REPEAT_LAST) begin
              do_step = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          S_RELEASE: begin
            if (i_Dir == 4'd0) begin
              state_d = S_IDLE;
            end
          end
          S_RESPAWN: begin
            if (cnt_q == RESPAWN_LAST) begin
              cnt_d   = '0;
              state_d = S_RELEASE;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          S_OVER: begin
          end
          default: begin
            state_d = S_RELEASE;
          end
        endcase

        // A blocked step still restarts the repeat timing above; it just doesn't move.
        if (do_step) begin
          if (step_goal) begin
            x_d        = X_BASE;
            y_d        = Y_BASE;
            level_up_d = 1'b1;
            state_d    = S_RELEASE;
            if (score_q != SCORE_MAX) begin
              score_d = score_q + SCORE_WIDTH'(1);
            end
          end else if (step_ok) begin
            x_d     = step_x;
            y_d     = step_y;
            moved_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= S_RELEASE;
      cnt_q      <= '0;
      dir_q      <= 4'd0;
      x_q        <= X_BASE;
      y_q        <= Y_BASE;
      score_q    <= '0;
      lives_q    <= LIVES_INI;
      moved_q    <= 1'b0;
      level_up_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      x_q        <= x_d;
      y_q        <= y_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      moved_q    <= moved_d;
      level_up_q <= level_up_d;
    end
  end

  assign o_Frog_X    = x_q;
  assign o_Frog_Y    = y_q;
  assign o_Score     = score_q;
  assign o_Lives     = lives_q;
  assign o_Moved     = moved_q;
  assign o_Level_Up  = level_up_q;
  assign o_Game_Over = (state_q == S_OVER);
  assign o_Draw_Frog = (state_q == S_RESPAWN) ? ~cnt_q[BLINK_BIT] : (state_q != S_OVER);

endmodule

// File: tb/tb_player_movement.sv
// Bench for player_movement: directed scenarios plus a random soak, all checked
// against a timestamp-based behavioural model of the player.
module tb_player_movement;

  localparam int TILE = 32;
  localparam int HV   = 640;
  localparam int VV   = 480;
  localparam int XB   = 320;
  localparam int YB   = 384;
  localparam int FD   = 4;
  localparam int RD   = 2;
  localparam int RC   = 8;
  localparam int BB   = 1;
  localparam int LI   = 2;
  localparam int SW   = 6;

  logic          clk = 1'b0;
  logic          i_Rst = 1'b1;
  logic          i_Game_Active = 1'b0;
  logic [3:0]    i_Dir = 4'd0;
  logic          i_Has_Collided = 1'b0;
  logic [9:0]    o_Frog_X;
  logic [9:0]    o_Frog_Y;
  logic          o_Draw_Frog;
  logic [SW-1:0] o_Score;
  logic [2:0]    o_Lives;
  logic          o_Level_Up;
  logic          o_Moved;
  logic          o_Game_Over;

  player_movement #(
    .FIRST_DELAY(FD), .REPEAT_DELAY(RD), .RESPAWN_CYCLES(RC),
    .BLINK_BIT(BB), .c_LIVES_INI(LI), .SCORE_WIDTH(SW)
  ) dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_Game_Active(i_Game_Active), .i_Dir(i_Dir),
    .i_Has_Collided(i_Has_Collided), .o_Frog_X(o_Frog_X), .o_Frog_Y(o_Frog_Y),
    .o_Draw_Frog(o_Draw_Frog), .o_Score(o_Score), .o_Lives(o_Lives),
    .o_Level_Up(o_Level_Up), .o_Moved(o_Moved), .o_Game_Over(o_Game_Over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] dut_vec;
  assign dut_vec = {o_Frog_X, o_Frog_Y, o_Score, o_Lives, o_Moved, o_Level_Up, o_Draw_Frog, o_Game_Over};

  // Model: time is counted in active edges; repeat steps are scheduled as absolute timestamps.
  int         m_t, m_x, m_y, m_score, m_lives, m_next, m_resp_start;
  logic [3:0] m_dir;
  bit         m_over, m_respawn, m_release, m_held, m_moved, m_lvl;

  function automatic void m_reset();
    m_t = 0; m_x = XB; m_y = YB; m_score = 0; m_lives = LI; m_next = 0; m_resp_start = 0;
    m_dir = 4'd0; m_over = 0; m_respawn = 0; m_release = 1; m_held = 0; m_moved = 0; m_lvl = 0;
  endfunction

  function automatic void m_move(input logic [3:0] d);
    if (d[3]) begin
      if (m_y > TILE) begin
        m_y = m_y - TILE; m_moved = 1;
      end else begin
        m_x = XB; m_y = YB; m_lvl = 1; m_held = 0; m_release = 1;
        if (m_score < (1 << SW) - 1) m_score = m_score + 1;
      end
    end else if (d[2]) begin
      if (m_y < VV - TILE) begin m_y = m_y + TILE; m_moved = 1; end
    end else if (d[1]) begin
      if (m_x >= TILE) begin m_x = m_x - TILE; m_moved = 1; end
    end else if (d[0]) begin
      if (m_x + TILE <= HV - TILE) begin m_x = m_x + TILE; m_moved = 1; end
    end
  endfunction

  function automatic void m_edge(input logic rst, input logic act, input logic [3:0] dir, input logic hit);
    m_moved = 0; m_lvl = 0;
    if (rst) begin m_reset(); return; end
    if (!act) return;
    m_t = m_t + 1;
    if (m_over) return;
    if (m_respawn) begin
      if (m_t == m_resp_start + RC) begin m_respawn = 0; m_release = 1; end
      return;
    end
    if (hit) begin
      m_x = XB; m_y = YB; m_lives = m_lives - 1; m_held = 0; m_release = 0;
      if (m_lives == 0) m_over = 1;
      else begin m_respawn = 1; m_resp_start = m_t; end
      return;
    end
    if (m_release) begin
      if (dir == 4'd0) m_release = 0;
      return;
    end
    if (m_held) begin
      if (dir != m_dir) m_held = 0;
      else if (m_t == m_next) begin m_next = m_t + RD; m_move(dir); end
      return;
    end
    if ($countones(dir) == 1) begin
      m_held = 1; m_dir = dir; m_next = m_t + FD; m_move(dir);
    end
  endfunction

  function automatic logic [32:0] m_vec();
    logic draw;
    if (m_over) draw = 1'b0;
    else if (m_respawn) draw = (((m_t - m_resp_start) >> BB) % 2) == 0;
    else draw = 1'b1;
    return {10'(m_x), 10'(m_y), 6'(m_score), 3'(m_lives), m_moved, m_lvl, draw, m_over};
  endfunction

  task automatic tick(input logic rst, input logic act, input logic [3:0] dir, input logic hit);
    i_Rst = rst; i_Game_Active = act; i_Dir = dir; i_Has_Collided = hit;
    @(posedge clk);
    m_edge(rst, act, dir, hit);
    #1;
    $display("t=%0t rst=%b act=%b dir=%b hit=%b X=%0d Y=%0d score=%0d lives=%0d moved=%b lvl=%b draw=%b over=%b",
             $time, rst, act, dir, hit, o_Frog_X, o_Frog_Y, o_Score, o_Lives, o_Moved, o_Level_Up,
             o_Draw_Frog, o_Game_Over);
  endtask

  task automatic test_reset();
    tick(1, 1, 4'd0, 0);
    n_checks++;
    if (dut_vec !== m_vec()) begin
      n_fail++; $display("FAIL reset_active: got %h expected %h", dut_vec, m_vec());
    end
    tick(1, 0, 4'b1000, 1);
    n_checks++;
    if ({o_Frog_X, o_Frog_Y, o_Score, o_Lives, o_Draw_Frog, o_Moved, o_Level_Up, o_Game_Over} !==
        {10'd320, 10'd384, 6'd0, 3'd2, 4'b1000}) begin
      n_fail++; $display("FAIL reset_inactive: got X=%0d Y=%0d S=%0d L=%0d D=%b M=%b U=%b O=%b required 320 384 0 2 1 0 0 0",
                         o_Frog_X, o_Frog_Y, o_Score, o_Lives, o_Draw_Frog, o_Moved, o_Level_Up, o_Game_Over);
    end
  endtask

  task automatic test_single_step();
    int idle = $urandom_range(1, 4);
    for (int i = 0; i < idle; i++) tick(0, 1, 4'd0, 0);
    tick(0, 1, 4'b1000, 0);
    n_checks++;
    if (o_Frog_Y !== 10'd352 || o_Moved !== 1'b1) begin
      n_fail++; $display("FAIL single_step: got Y=%0d moved=%b required Y=352 moved=1", o_Frog_Y, o_Moved);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, 4'd0, 0);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL single_step_after cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
  endtask

  task automatic test_hold_right();
    tick(1, 1, 4'd0, 0);
    tick(0, 1, 4'd0, 0);
    for (int i = 0; i < 30; i++) begin
      tick(0, 1, 4'b0001, 0);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL hold_right cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
    n_checks++;
    if (o_Frog_X !== 10'd608) begin
      n_fail++; $display("FAIL hold_right_edge: got X=%0d required 608", o_Frog_X);
    end
    tick(0, 1, 4'd0, 0);
  endtask

  task automatic test_invalid_and_change();
    tick(1, 1, 4'd0, 0);
    tick(0, 1, 4'd0, 0);
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, (i < 3) ? 4'b1010 : 4'b1111, 0);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL multi_dir cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
    tick(0, 1, 4'd0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, (i < 6) ? 4'b0010 : 4'b0100, 0);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL dir_change cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
  endtask

  task automatic test_goal();
    int pulses = 0;
    tick(1, 1, 4'd0, 0);
    tick(0, 1, 4'd0, 0);
    for (int i = 0; i < 32; i++) begin
      tick(0, 1, 4'b1000, 0);
      pulses += int'(o_Level_Up);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL goal cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
    n_checks++;
    if (pulses != 1 || o_Score !== 6'd1 || o_Frog_Y !== 10'd384) begin
      n_fail++; $display("FAIL goal_summary: got pulses=%0d score=%0d Y=%0d required 1 1 384", pulses, o_Score, o_Frog_Y);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, (i == 0) ? 4'd0 : 4'b1000, 0);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL goal_release cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
  endtask

  task automatic test_collision();
    int d = $urandom_range(1, 6);
    tick(1, 1, 4'd0, 0);
    tick(0, 1, 4'd0, 0);
    for (int i = 0; i < d; i++) tick(0, 1, 4'b1000, 0);
    for (int i = 0; i < 14; i++) begin
      tick(0, 1, (i < 12) ? 4'b1000 : 4'd0, (i < 3));
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL collision cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
    tick(0, 1, 4'd0, 1);
    n_checks++;
    if (o_Lives !== 3'd0 || o_Game_Over !== 1'b1 || o_Draw_Frog !== 1'b0) begin
      n_fail++; $display("FAIL game_over: got lives=%0d over=%b draw=%b required 0 1 0", o_Lives, o_Game_Over, o_Draw_Frog);
    end
    for (int i = 0; i < 6; i++) begin
      tick(0, 1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL over_hold cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
    tick(1, 0, 4'b1000, 0);
    n_checks++;
    if (dut_vec !== m_vec()) begin
      n_fail++; $display("FAIL reset_from_over: got %h expected %h", dut_vec, m_vec());
    end
  endtask

  task automatic test_freeze();
    tick(1, 1, 4'd0, 0);
    tick(0, 1, 4'd0, 0);
    for (int i = 0; i < 22; i++) begin
      if (i >= 3 && i < 13) tick(0, 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else tick(0, 1, 4'b0001, 0);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL freeze cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
  endtask

  task automatic test_random_soak();
    logic [3:0] dir_tbl [10] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd8, 4'd3, 4'hA, 4'hF, 4'd0};
    logic [3:0] dir = 4'd0;
    tick(1, 1, 4'd0, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3) dir = dir_tbl[$urandom_range(0, 9)];
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, dir, $urandom_range(0, 59) == 0);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_fail++; $display("FAIL soak cyc %0d: got %h expected %h", i, dut_vec, m_vec());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single_step();
    test_hold_right();
    test_invalid_and_change();
    test_goal();
    test_collision();
    test_freeze();
    test_random_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
